mmr_mismatch_collector: RTL

// Sink for the mismatch_o flags of N_CH K-modular-redundant registers.
// - Turns each mismatch rising edge into one event and counts events per channel in saturating counters.
// - Reports events to the slow-control side as a valid/ready stream of {channel, count}.
// - Sits between the voted-register array and the SEU monitoring registers.

---
 rtl/mmr_pkg.sv | 22 ++
 rtl/mmr_rr_arbiter.sv | 35 +++
 rtl/mmr_mismatch_collector.sv | 111 +++++++++++
 3 files changed

// File: rtl/mmr_pkg.sv
// Shared types and helpers for the mismatch collector.
//   N_CH, CNT_W, CH_W : default geometry used by the event record type
//   mmr_evt_t         : {channel, count} event record
//   sat_inc()         : saturating increment of a counter of a given width (width <= 32)
package mmr_pkg;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned CH_W  = $clog2(N_CH);

  typedef struct packed {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] count;
  } mmr_evt_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (cnt >= max_val) ? max_val : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mmr_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req          : request vector
//   ptr          : index where the search starts (wraps N_CH-1 -> 0)
//   grant_onehot : one-hot grant, zero when no request
//   grant_idx    : binary index of the grant, zero when no request
module mmr_rr_arbiter #(
  parameter int unsigned N_CH = 8,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] ptr,
  output logic [N_CH-1:0] grant_onehot,
  output logic [CH_W-1:0] grant_idx
);
  import mmr_pkg::*;

  logic        found;
  int unsigned idx;

  always_comb begin
    found        = 1'b0;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = (32'(ptr) + i) % N_CH;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_idx         = CH_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mmr_mismatch_collector.sv
// Collects mismatch flags from N_CH redundant registers.
//   clk_i, rst_n_i : clock, async active-low reset
//   mismatch_i     : per-channel mismatch flags (rising edge = one event)
//   clear_i        : sync clear of counters, pending, overflow, output record, rr pointer
//   evt_*          : valid/ready record {channel, post-increment count}
//   pending_o      : channels with events not yet loaded into the record register
//   overflow_o     : sticky, some counter reached all-ones
//   any_error_o    : OR of registered mismatch flags
// CNT_W must not exceed 32 (sat_inc width).
module mmr_mismatch_collector #(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CH_W = $clog2(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [N_CH-1:0]  mismatch_i,
  input  logic             clear_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [CH_W-1:0]  evt_ch_o,
  output logic [CNT_W-1:0] evt_count_o,
  output logic [N_CH-1:0]  pending_o,
  output logic             overflow_o,
  output logic             any_error_o
);
  import mmr_pkg::*;

  logic [N_CH-1:0]  mismatch_q, edge_det, pending_q, pending_d, pending_eff, grant_onehot;
  logic [CH_W-1:0]  grant_idx, ptr_q, ptr_d, ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d, overflow_q, overflow_d, load, sat_any;

  mmr_rr_arbiter #(
    .N_CH(N_CH)
  ) u_arb (
    .req         (pending_eff),
    .ptr         (ptr_q),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    edge_det    = mismatch_i & ~mismatch_q;
    pending_eff = pending_q | edge_det;
    load        = (|pending_eff) && (!valid_q || evt_ready_i);
    sat_any     = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      cnt_d[c] = edge_det[c] ? CNT_W'(sat_inc(32'(cnt_q[c]), CNT_W)) : cnt_q[c];
      if (&cnt_d[c]) sat_any = 1'b1;
    end
    pending_d  = pending_eff;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q | sat_any;
    if (load) begin
      // Snapshot already includes a same-cycle edge, so the grant clears pending outright.
      pending_d = pending_eff & ~grant_onehot;
      ch_d      = grant_idx;
      count_d   = cnt_d[grant_idx];
      valid_d   = 1'b1;
      ptr_d     = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
    end else if (evt_ready_i) begin
      valid_d = 1'b0;
    end
    if (clear_i) begin
      for (int unsigned c = 0; c < N_CH; c++) cnt_d[c] = '0;
      pending_d  = '0;
      ptr_d      = '0;
      ch_d       = '0;
      count_d    = '0;
      valid_d    = 1'b0;
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned c = 0; c < N_CH; c++) cnt_q[c] <= '0;
      mismatch_q <= '0;
      pending_q  <= '0;
      ptr_q      <= '0;
      ch_q       <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) cnt_q[c] <= cnt_d[c];
      // Keeps tracking through clear so a flag already high yields no event afterwards.
      mismatch_q <= mismatch_i;
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      ch_q       <= ch_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_ch_o    = ch_q;
  assign evt_count_o = count_q;
  assign pending_o   = pending_q;
  assign overflow_o  = overflow_q;
  assign any_error_o = |mismatch_q;

endmodule
